// File: rtl/pulse_period_checker_if.sv
// Signal bundle between a pulse source and the period checker that watches it.
// The source drives the strobe; the checker returns its measurement and health flags.
interface pulse_period_checker_if #(
    parameter int WIDTH = 8
);
    logic             pulse_in;
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             err;

    modport master (
        output pulse_in,
        input  period,
        input  period_valid,
        input  locked,
        input  err
    );

    modport slave (
        input  pulse_in,
        output period,
        output period_valid,
        output locked,
        output err
    );
endinterface

// File: rtl/pulse_period_checker.sv
// Measures the clk-cycle spacing of rising edges on a strobe and compares it with DIV.
// Declares lock after LOCK_COUNT good periods; flags bad periods and missing pulses.
module pulse_period_checker #(
    parameter int DIV        = 3,
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    pulse_period_checker_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX   = '1;
    localparam logic [WIDTH-1:0] DIV_V = WIDTH'(DIV);
    localparam int               GW    = $clog2(LOCK_COUNT + 1);
    localparam logic [GW-1:0]    LOCK_G = GW'(LOCK_COUNT);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [GW-1:0]    good_q, good_d;
    logic             p_q;
    logic [WIDTH-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;

    logic edgeSeen;
    logic match;

    assign edgeSeen = bus.pulse_in & ~p_q;
    assign match    = (cnt_q == DIV_V);

    // The counter value present at an edge is the interval just completed.
    always_comb begin
        state_d        = state_q;
        good_d         = good_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        err_d          = 1'b0;

        if (edgeSeen) begin
            cnt_d = WIDTH'(1);
        end else if (cnt_q == MAX) begin
            cnt_d = MAX;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (edgeSeen) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            end
            ACQUIRE, LOCKED: begin
                if (edgeSeen) begin
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    if (match) begin
                        if (good_q != LOCK_G) begin
                            good_d = good_q + 1'b1;
                        end
                        if (good_d == LOCK_G) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        err_d   = 1'b1;
                        good_d  = '0;
                        state_d = ACQUIRE;
                    end
                end else if (cnt_q == MAX) begin
                    // Saturated counter means the strobe stopped; IDLE never re-fires this.
                    err_d   = 1'b1;
                    good_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                good_d  = '0;
            end
        endcase

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            good_q         <= '0;
            p_q            <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            good_q         <= good_d;
            p_q            <= bus.pulse_in;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            err_q          <= err_d;
        end
    end

    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;
    assign bus.locked       = locked_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_pulse_period_checker.sv
// Directed bench for pulse_period_checker with DIV=3, WIDTH=8, LOCK_COUNT=4.
// Inputs change 1ns after a rising clk edge; outputs are sampled at that same point.
module tb_pulse_period_checker;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    pulse_period_checker_if #(.WIDTH(8)) ppcIf ();

    pulse_period_checker #(
        .DIV(3),
        .WIDTH(8),
        .LOCK_COUNT(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ppcIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive one clk cycle of pulse_in and land 1ns after the edge that sampled it.
    task automatic applyStimulus(input logic p);
        ppcIf.pulse_in = p;
        @(posedge clk);
        #1;
    endtask

    // Low cycles must be quiet; the closing high cycle is the edge under test.
    task automatic sendEdge(input int zeros, input logic expPv, input int expPeriod,
                            input logic expErr, input logic expLocked);
        for (int i = 0; i < zeros; i++) begin
            applyStimulus(1'b0);
            checkOutput("gap_period_valid", 32'(ppcIf.period_valid), 32'd0);
            checkOutput("gap_err", 32'(ppcIf.err), 32'd0);
        end
        applyStimulus(1'b1);
        checkOutput("edge_period_valid", 32'(ppcIf.period_valid), 32'(expPv));
        checkOutput("edge_period", 32'(ppcIf.period), 32'(expPeriod));
        checkOutput("edge_err", 32'(ppcIf.err), 32'(expErr));
        checkOutput("edge_locked", 32'(ppcIf.locked), 32'(expLocked));
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        ppcIf.pulse_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_period", 32'(ppcIf.period), 32'd0);
        checkOutput("reset_period_valid", 32'(ppcIf.period_valid), 32'd0);
        checkOutput("reset_locked", 32'(ppcIf.locked), 32'd0);
        checkOutput("reset_err", 32'(ppcIf.err), 32'd0);
        reset = 1'b0;

        $display("[TB] scenario 1: 1-in-3 strobe from reset");
        sendEdge(2, 1'b0, 0, 1'b0, 1'b0);
        sendEdge(2, 1'b1, 3, 1'b0, 1'b0);
        sendEdge(2, 1'b1, 3, 1'b0, 1'b0);
        sendEdge(2, 1'b1, 3, 1'b0, 1'b0);
        sendEdge(2, 1'b1, 3, 1'b0, 1'b1);

        $display("[TB] scenario 2: one 4-cycle gap while locked");
        sendEdge(3, 1'b1, 4, 1'b1, 1'b0);
        sendEdge(2, 1'b1, 3, 1'b0, 1'b0);
        sendEdge(2, 1'b1, 3, 1'b0, 1'b0);
        sendEdge(2, 1'b1, 3, 1'b0, 1'b0);
        sendEdge(2, 1'b1, 3, 1'b0, 1'b1);

        $display("[TB] scenario 3: level held high");
        sendEdge(2, 1'b1, 3, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1);
            checkOutput("held_period_valid", 32'(ppcIf.period_valid), 32'd0);
            checkOutput("held_err", 32'(ppcIf.err), 32'd0);
        end
        sendEdge(2, 1'b1, 12, 1'b1, 1'b0);

        $display("[TB] scenario 4: pulses stop after lock");
        sendEdge(2, 1'b1, 3, 1'b0, 1'b0);
        sendEdge(2, 1'b1, 3, 1'b0, 1'b0);
        sendEdge(2, 1'b1, 3, 1'b0, 1'b0);
        sendEdge(2, 1'b1, 3, 1'b0, 1'b1);
        for (int i = 1; i < 255; i++) begin
            applyStimulus(1'b0);
            checkOutput("pre_timeout_err", 32'(ppcIf.err), 32'd0);
        end
        checkOutput("pre_timeout_locked", 32'(ppcIf.locked), 32'd1);
        applyStimulus(1'b0);
        checkOutput("timeout_err", 32'(ppcIf.err), 32'd1);
        checkOutput("timeout_locked", 32'(ppcIf.locked), 32'd0);
        checkOutput("timeout_period_valid", 32'(ppcIf.period_valid), 32'd0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0);
            checkOutput("idle_err", 32'(ppcIf.err), 32'd0);
        end

        $display("[TB] scenario 5: 1-in-2 strobe");
        sendEdge(1, 1'b0, 3, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            sendEdge(1, 1'b1, 2, 1'b1, 1'b0);
        end

        $display("[TB] scenario 6: reset mid-acquire");
        sendEdge(2, 1'b1, 3, 1'b0, 1'b0);
        sendEdge(2, 1'b1, 3, 1'b0, 1'b0);
        applyStimulus(1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_period", 32'(ppcIf.period), 32'd0);
        checkOutput("async_reset_period_valid", 32'(ppcIf.period_valid), 32'd0);
        checkOutput("async_reset_locked", 32'(ppcIf.locked), 32'd0);
        checkOutput("async_reset_err", 32'(ppcIf.err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sendEdge(2, 1'b0, 0, 1'b0, 1'b0);
        sendEdge(2, 1'b1, 3, 1'b0, 1'b0);
        sendEdge(2, 1'b1, 3, 1'b0, 1'b0);
        sendEdge(2, 1'b1, 3, 1'b0, 1'b0);
        sendEdge(2, 1'b1, 3, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
